// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle LoongArch core: fetch FSM encoding,
// reset PC and the NOP word used for suppressed fetches.
package cpu_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0340_0000;  // andi r0,r0,0

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, reads the 1-cycle synchronous instruction SRAM,
// buffers one instruction and hands it to decode over valid/ready.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_sram_en,
  output logic              inst_sram_we,
  output logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_wdata,
  input  logic [31:0]       inst_sram_rdata,
  output logic              fs_valid,
  input  logic              ds_ready,
  output logic [INST_W-1:0] fs_inst,
  output logic [31:0]       fs_pc,
  output logic              fs_adef,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  output logic [31:0]       fetch_cnt,
  output fetch_state_e      dbg_state
);

  // Handshake: fs_valid holds fs_inst/fs_pc/fs_adef stable until the cycle
  // where ds_ready is also high (fire); the instruction is consumed on that edge.

  fetch_state_e state;
  logic [31:0]  pc;
  logic         pc_misaligned;
  logic         fire;

  assign pc_misaligned = |pc[1:0];
  assign fire          = fs_valid & ds_ready;

  // SRAM controls come straight from registers; a misaligned PC never reaches the SRAM.
  assign inst_sram_en    = (state == S_REQ) & ~pc_misaligned;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = pc;
  assign inst_sram_wdata = 32'h0;
  assign dbg_state       = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      fs_valid  <= 1'b0;
      fs_inst   <= '0;
      fs_pc     <= RESET_PC;
      fs_adef   <= 1'b0;
      fetch_cnt <= 32'h0;
    end else begin
      if (fire) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (br_valid) begin
        // A redirect abandons any in-flight read; a coincident fire still counts.
        pc       <= br_target;
        state    <= S_REQ;
        fs_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_REQ;
          end
          S_REQ: begin
            state <= S_RESP;
          end
          S_RESP: begin
            fs_inst  <= pc_misaligned ? NOP_INST : inst_sram_rdata;
            fs_pc    <= pc;
            fs_adef  <= pc_misaligned;
            fs_valid <= 1'b1;
            state    <= S_VALID;
          end
          S_VALID: begin
            if (ds_ready) begin
              pc       <= pc + 32'd4;
              fs_valid <= 1'b0;
              state    <= S_REQ;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
